// File: rtl/mux4_rr_arbiter_if.sv
// Handshake and datapath bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests, lane data and downstream ready; the slave side is the arbiter.
interface mux4_rr_arbiter_if #(
   parameter int DW = 1
);
   logic [3:0]      req;
   logic [4*DW-1:0] din;
   logic            out_ready;
   logic [3:0]      grant;
   logic [1:0]      sel;
   logic [DW-1:0]   dout;
   logic            out_valid;

   modport master (
      output req, din, out_ready,
      input  grant, sel, dout, out_valid
   );

   modport slave (
      input  req, din, out_ready,
      output grant, sel, dout, out_valid
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: drives sel/grant, forwards the owner's lane as
// a valid/ready stream, and forces rotation after HOLD_MAX transfers when others wait.
module mux4_rr_arbiter #(
   parameter int DW       = 1,
   parameter int HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [1:0] sel_q, sel_nxt;
   logic [1:0] ptr_q, ptr_nxt;
   logic [3:0] grant_q, grant_nxt;
   logic [3:0] cnt_q, cnt_nxt;

   logic       out_valid;
   logic       xfer;
   logic       hold_done;
   logic       others_req;
   logic       release_now;

   logic [3:0] arb_req;
   logic [1:0] arb_base;
   logic [1:0] arb_idx;
   logic       arb_found;

   assign out_valid   = (state == GRANT) && bus.req[sel_q];
   assign xfer        = out_valid && bus.out_ready;
   assign hold_done   = ({1'b0, cnt_q} + 5'd1) >= 5'(HOLD_MAX);
   assign others_req  = |(bus.req & ~grant_q);
   assign release_now = (state == GRANT) &&
                        (!bus.req[sel_q] || (xfer && hold_done && others_req));

   // On release the search restarts just past the old owner, which is itself masked out.
   assign arb_req  = (state == GRANT) ? (bus.req & ~grant_q) : bus.req;
   assign arb_base = (state == GRANT) ? 2'(sel_q + 2'd1) : ptr_q;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = arb_base;
      // Walk from the farthest offset down so the nearest requester past arb_base wins.
      for (int i = 3; i >= 0; i--) begin
         if (arb_req[2'(arb_base + 2'(i))]) begin
            arb_found = 1'b1;
            arb_idx   = 2'(arb_base + 2'(i));
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      sel_nxt   = sel_q;
      ptr_nxt   = ptr_q;
      grant_nxt = grant_q;
      cnt_nxt   = cnt_q;

      unique case (state)
         IDLE: begin
            if (arb_found) begin
               state_nxt = GRANT;
               sel_nxt   = arb_idx;
               grant_nxt = 4'b0001 << arb_idx;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (xfer && (cnt_q < 4'(HOLD_MAX)))
               cnt_nxt = cnt_q + 4'd1;
            if (release_now) begin
               ptr_nxt = arb_base;
               cnt_nxt = '0;
               if (arb_found) begin
                  sel_nxt   = arb_idx;
                  grant_nxt = 4'b0001 << arb_idx;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) begin
         state   <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         sel_q   <= sel_nxt;
         ptr_q   <= ptr_nxt;
         grant_q <= grant_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.sel       = sel_q;
   assign bus.out_valid = out_valid;
   assign bus.dout      = out_valid ? bus.din[sel_q*DW +: DW] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: expected owner lanes are queued as stimulus is
// applied and popped whenever the arbiter completes a transfer, plus direct point checks.
module tb_mux4_rr_arbiter;
   localparam int DW       = 1;
   localparam int HOLD_MAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   logic [1:0] exp_q[$];

   mux4_rr_arbiter_if #(.DW(DW)) bus ();

   mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard sample on the falling edge, then advance to just past the next rising edge.
   task automatic step();
      logic [1:0] lane;
      @(negedge clk);
      if (mon_en && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_xfer", 32'(bus.grant), 32'd0);
         end else begin
            lane = exp_q.pop_front();
            check("sb_grant", 32'(bus.grant), 32'(4'b0001 << lane));
            check("sb_sel",   32'(bus.sel),   32'(lane));
            check("sb_dout",  32'(bus.dout),  32'(bus.din[lane]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req       = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req       = '0;
      bus.din       = '0;
      bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(bus.grant),     32'd0);
      check("rst_sel",   32'(bus.sel),       32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_dout",  32'(bus.dout),      32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single requester: one-cycle grant latency, then back to idle when it drops.
      bus.req       = 4'b0010;
      bus.din       = 4'b0010;
      bus.out_ready = 1'b1;
      check("t1_idle_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("t1_grant", 32'(bus.grant),     32'h2);
      check("t1_sel",   32'(bus.sel),       32'd1);
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_dout",  32'(bus.dout),      32'd1);
      bus.req = 4'b0000;
      step();
      check("t1_idle_grant", 32'(bus.grant),     32'd0);
      check("t1_idle_sel",   32'(bus.sel),       32'd1);
      check("t1_idle_valid", 32'(bus.out_valid), 32'd0);

      // All lanes requesting: four transfers per owner in ring order, no bubbles.
      do_reset();
      bus.out_ready = 1'b1;
      bus.req       = 4'b1111;
      for (int i = 0; i < 20; i++) exp_q.push_back(2'((i / 4) % 4));
      mon_en = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         bus.din = 4'($urandom);
         step();
      end
      mon_en = 1'b0;
      check("rr_drain", 32'(exp_q.size()), 32'd0);
      check("rr_next_owner", 32'(bus.grant), 32'h2);
      exp_q.delete();

      // Stall on lane 2: owner, select and data frozen, count frozen until ready returns.
      do_reset();
      bus.req = 4'b0100;
      step();
      check("st_grant", 32'(bus.grant), 32'h4);
      mon_en        = 1'b1;
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      exp_q.push_back(2'd2);
      step();
      bus.out_ready = 1'b0;
      bus.din       = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         check("st_sel",   32'(bus.sel),       32'd2);
         check("st_grant", 32'(bus.grant),     32'h4);
         check("st_valid", 32'(bus.out_valid), 32'd1);
         check("st_dout",  32'(bus.dout),      32'd1);
      end
      bus.out_ready = 1'b1;
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      for (int i = 0; i < 4; i++) begin
         bus.din = 4'($urandom);
         step();
      end
      mon_en = 1'b0;
      check("st_drain", 32'(exp_q.size()), 32'd0);
      check("st_next_owner", 32'(bus.grant), 32'h8);
      exp_q.delete();

      // Lone owner may exceed HOLD_MAX; a newcomer preempts it after its next transfer.
      do_reset();
      bus.out_ready = 1'b1;
      bus.req       = 4'b0001;
      step();
      check("ho_grant", 32'(bus.grant), 32'h1);
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(2'd0);
      for (int i = 0; i < 10; i++) begin
         bus.din = 4'($urandom);
         step();
      end
      check("ho_still_owner", 32'(bus.grant), 32'h1);
      bus.req = 4'b1001;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd3);
      bus.din = 4'($urandom);
      step();
      check("ho_preempt", 32'(bus.grant), 32'h8);
      bus.din = 4'($urandom);
      step();
      mon_en = 1'b0;
      check("ho_drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();

      // Asynchronous reset while lane 3 owns; the next arbitration starts from lane 0.
      rst_n = 1'b0;
      #1;
      check("ar_grant", 32'(bus.grant),     32'd0);
      check("ar_sel",   32'(bus.sel),       32'd0);
      check("ar_valid", 32'(bus.out_valid), 32'd0);
      check("ar_dout",  32'(bus.dout),      32'd0);
      bus.req = 4'b1001;
      #2 rst_n = 1'b1;
      step();
      check("ar_first_win", 32'(bus.grant), 32'h1);
      check("ar_first_sel", 32'(bus.sel),   32'd0);

      // Owner abandons during a stall: handover to the next pending lane at that edge.
      do_reset();
      bus.out_ready = 1'b1;
      bus.req       = 4'b0010;
      step();
      check("ab_grant", 32'(bus.grant), 32'h2);
      bus.req       = 4'b0110;
      bus.out_ready = 1'b0;
      step();
      check("ab_stall_sel", 32'(bus.sel), 32'd1);
      bus.req = 4'b0100;
      #1;
      check("ab_drop_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("ab_new_grant", 32'(bus.grant),     32'h4);
      check("ab_new_sel",   32'(bus.sel),       32'd2);
      check("ab_new_valid", 32'(bus.out_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
